// File: rtl/scan_sequencer.sv
// ============================================================================
// scan_sequencer : film scanner top-level sequencer (home, step/settle/capture)
// Rev 1.0
// ============================================================================
`default_nettype none

module scan_sequencer #(
   parameter int HOME_MAX_STEPS = 20000,
   parameter int CAP_TIMEOUT    = 2000000,
   parameter int CNT_W          = 24
) (
   input  logic        clk_100M,
   input  logic        nrst,
   input  logic        cmd_start,
   input  logic        cmd_abort,
   input  logic [15:0] cfg_lines,
   input  logic [7:0]  cfg_steps_per_line,
   input  logic [15:0] cfg_step_half,
   input  logic [15:0] cfg_settle,
   input  logic        mtr_nhome,
   input  logic        mtr_nflt,
   input  logic        ccd_line_done,
   output logic        mtr_step,
   output logic        mtr_dir,
   output logic        mtr_nen,
   output logic        ccd_en,
   output logic        busy,
   output logic        done,
   output logic        fault,
   output logic [1:0]  err_code,
   output logic [15:0] line_count
);

   localparam int HC_W = $clog2(HOME_MAX_STEPS + 1);

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_ENABLE   = 4'd1,
      S_HOME_CHK = 4'd2,
      S_HOME_HI  = 4'd3,
      S_HOME_LO  = 4'd4,
      S_SCAN_SET = 4'd5,
      S_CAPTURE  = 4'd6,
      S_STEP_HI  = 4'd7,
      S_STEP_LO  = 4'd8,
      S_FIN      = 4'd9,
      S_DONE     = 4'd10,
      S_FAULT    = 4'd11
   } state_t;

   function automatic logic is_busy(input state_t s);
      return !(s inside {S_IDLE, S_DONE, S_FAULT});
   endfunction

   state_t            r_state;
   state_t            w_state_nxt;
   logic [CNT_W-1:0]  r_tmr;
   logic [HC_W-1:0]   r_home_cnt;
   logic [7:0]        r_step_cnt;
   logic [15:0]       r_lines;
   logic [7:0]        r_spl;
   logic [15:0]       r_half;
   logic [15:0]       r_settle;

   logic              r_nhome_s1, r_nhome_s2;
   logic              r_nflt_s1, r_nflt_s2;
   logic              r_ld_s1, r_ld_s2, r_ld_s3;

   logic              r_step, r_dir, r_nen, r_ccd_en, r_busy, r_done, r_fault;
   logic [1:0]        r_err;
   logic [15:0]       r_line_cnt;

   logic              w_ld_edge;
   logic [CNT_W-1:0]  w_tmr_inc;
   logic [CNT_W-1:0]  w_half_ext;
   logic [CNT_W-1:0]  w_settle_ext;
   logic              w_half_end;
   logic              w_settle_end;
   logic              w_cap_to;
   logic              w_home_max;
   logic              w_step_last;
   logic              w_busy_now;
   logic              w_busy_nxt;
   logic [1:0]        w_err_nxt;
   logic              w_dir_nxt;
   logic              w_start_acc;
   logic              w_line_inc;
   logic              w_home_inc;
   logic              w_step_inc;
   logic              w_step_clr;

   // Home and fault are idle-high, so their synchronisers reset to 1
   always_ff @(posedge clk_100M or negedge nrst) begin
      if (!nrst) begin
         r_nhome_s1 <= 1'b1;
         r_nhome_s2 <= 1'b1;
         r_nflt_s1  <= 1'b1;
         r_nflt_s2  <= 1'b1;
         r_ld_s1    <= 1'b0;
         r_ld_s2    <= 1'b0;
         r_ld_s3    <= 1'b0;
      end else begin
         r_nhome_s1 <= mtr_nhome;
         r_nhome_s2 <= r_nhome_s1;
         r_nflt_s1  <= mtr_nflt;
         r_nflt_s2  <= r_nflt_s1;
         r_ld_s1    <= ccd_line_done;
         r_ld_s2    <= r_ld_s1;
         r_ld_s3    <= r_ld_s2;
      end
   end

   assign w_ld_edge    = r_ld_s2 & ~r_ld_s3;
   assign w_tmr_inc    = r_tmr + CNT_W'(1);
   assign w_half_ext   = {{(CNT_W-16){1'b0}}, r_half};
   assign w_settle_ext = {{(CNT_W-16){1'b0}}, r_settle};
   assign w_half_end   = (w_tmr_inc == w_half_ext);
   assign w_settle_end = (w_tmr_inc >= w_settle_ext);
   assign w_cap_to     = (r_tmr == CNT_W'(CAP_TIMEOUT - 1));
   assign w_home_max   = (r_home_cnt == HC_W'(HOME_MAX_STEPS));
   assign w_step_last  = ((r_step_cnt + 8'd1) == r_spl);
   assign w_busy_now   = is_busy(r_state);
   assign w_busy_nxt   = is_busy(w_state_nxt);

   always_comb begin
      w_state_nxt = r_state;
      w_err_nxt   = r_err;
      w_dir_nxt   = r_dir;
      w_start_acc = 1'b0;
      w_line_inc  = 1'b0;
      w_home_inc  = 1'b0;
      w_step_inc  = 1'b0;
      w_step_clr  = 1'b0;
      if (cmd_abort) begin
         w_state_nxt = S_IDLE;
         w_err_nxt   = 2'd0;
      end else if (w_busy_now && !r_nflt_s2) begin
         w_state_nxt = S_FAULT;
         w_err_nxt   = 2'd1;
      end else begin
         case (r_state)
            S_IDLE, S_DONE, S_FAULT: begin
               if (cmd_start) begin
                  w_start_acc = 1'b1;
                  w_state_nxt = S_ENABLE;
                  w_err_nxt   = 2'd0;
               end
            end
            S_ENABLE: begin
               if (w_settle_end) w_state_nxt = S_HOME_CHK;
            end
            S_HOME_CHK: begin
               if (!r_nhome_s2) begin
                  w_dir_nxt   = 1'b1;
                  w_state_nxt = S_SCAN_SET;
               end else if (w_home_max) begin
                  w_state_nxt = S_FAULT;
                  w_err_nxt   = 2'd2;
               end else begin
                  w_dir_nxt   = 1'b0;
                  w_state_nxt = S_HOME_HI;
               end
            end
            S_HOME_HI: begin
               if (w_half_end) w_state_nxt = S_HOME_LO;
            end
            S_HOME_LO: begin
               if (w_half_end) begin
                  w_home_inc  = 1'b1;
                  w_state_nxt = S_HOME_CHK;
               end
            end
            S_SCAN_SET: begin
               if (r_line_cnt == r_lines)  w_state_nxt = S_FIN;
               else if (w_settle_end)      w_state_nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
               // A line-done edge in the timeout cycle still counts the line
               if (w_ld_edge) begin
                  w_line_inc = 1'b1;
                  if (r_spl == 8'd0) begin
                     w_state_nxt = S_SCAN_SET;
                  end else begin
                     w_step_clr  = 1'b1;
                     w_state_nxt = S_STEP_HI;
                  end
               end else if (w_cap_to) begin
                  w_state_nxt = S_FAULT;
                  w_err_nxt   = 2'd3;
               end
            end
            S_STEP_HI: begin
               if (w_half_end) w_state_nxt = S_STEP_LO;
            end
            S_STEP_LO: begin
               if (w_half_end) begin
                  if (w_step_last) begin
                     w_state_nxt = S_SCAN_SET;
                  end else begin
                     w_step_inc  = 1'b1;
                     w_state_nxt = S_STEP_HI;
                  end
               end
            end
            S_FIN:   w_state_nxt = S_DONE;
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   // Outputs decode the next state so they change on the transition edge
   always_ff @(posedge clk_100M or negedge nrst) begin
      if (!nrst) begin
         r_state    <= S_IDLE;
         r_tmr      <= '0;
         r_home_cnt <= '0;
         r_step_cnt <= 8'd0;
         r_lines    <= 16'd0;
         r_spl      <= 8'd0;
         r_half     <= 16'd1;
         r_settle   <= 16'd0;
         r_step     <= 1'b0;
         r_dir      <= 1'b0;
         r_nen      <= 1'b1;
         r_ccd_en   <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_fault    <= 1'b0;
         r_err      <= 2'd0;
         r_line_cnt <= 16'd0;
      end else begin
         r_state <= w_state_nxt;
         if ((w_state_nxt != r_state) || !w_busy_nxt) r_tmr <= '0;
         else                                          r_tmr <= w_tmr_inc;

         if (w_start_acc) begin
            r_lines    <= cfg_lines;
            r_spl      <= cfg_steps_per_line;
            r_half     <= (cfg_step_half == 16'd0) ? 16'd1 : cfg_step_half;
            r_settle   <= cfg_settle;
            r_line_cnt <= 16'd0;
            r_home_cnt <= '0;
         end else begin
            if (w_line_inc) r_line_cnt <= r_line_cnt + 16'd1;
            if (w_home_inc) r_home_cnt <= r_home_cnt + HC_W'(1);
         end

         if (w_step_clr)      r_step_cnt <= 8'd0;
         else if (w_step_inc) r_step_cnt <= r_step_cnt + 8'd1;

         r_dir    <= w_dir_nxt;
         r_err    <= w_err_nxt;
         r_step   <= (w_state_nxt == S_HOME_HI) || (w_state_nxt == S_STEP_HI);
         r_ccd_en <= (w_state_nxt == S_CAPTURE);
         r_nen    <= (w_state_nxt inside {S_IDLE, S_FIN, S_DONE, S_FAULT});
         r_busy   <= w_busy_nxt;
         r_done   <= (w_state_nxt == S_FIN);
         r_fault  <= (w_state_nxt == S_FAULT);
      end
   end

   assign mtr_step   = r_step;
   assign mtr_dir    = r_dir;
   assign mtr_nen    = r_nen;
   assign ccd_en     = r_ccd_en;
   assign busy       = r_busy;
   assign done       = r_done;
   assign fault      = r_fault;
   assign err_code   = r_err;
   assign line_count = r_line_cnt;

endmodule

`default_nettype wire

// File: tb/tb_scan_sequencer.sv
// ============================================================================
// tb_scan_sequencer : directed self-checking bench for scan_sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_scan_sequencer;

   logic        clk_100M = 1'b0;
   logic        nrst;
   logic        cmd_start;
   logic        cmd_abort;
   logic [15:0] cfg_lines;
   logic [7:0]  cfg_steps_per_line;
   logic [15:0] cfg_step_half;
   logic [15:0] cfg_settle;
   logic        mtr_nhome;
   logic        mtr_nflt;
   logic        ccd_line_done = 1'b0;
   logic        mtr_step;
   logic        mtr_dir;
   logic        mtr_nen;
   logic        ccd_en;
   logic        busy;
   logic        done;
   logic        fault;
   logic [1:0]  err_code;
   logic [15:0] line_count;

   scan_sequencer #(
      .HOME_MAX_STEPS (8),
      .CAP_TIMEOUT    (100),
      .CNT_W          (24)
   ) u_dut (
      .clk_100M           (clk_100M),
      .nrst               (nrst),
      .cmd_start          (cmd_start),
      .cmd_abort          (cmd_abort),
      .cfg_lines          (cfg_lines),
      .cfg_steps_per_line (cfg_steps_per_line),
      .cfg_step_half      (cfg_step_half),
      .cfg_settle         (cfg_settle),
      .mtr_nhome          (mtr_nhome),
      .mtr_nflt           (mtr_nflt),
      .ccd_line_done      (ccd_line_done),
      .mtr_step           (mtr_step),
      .mtr_dir            (mtr_dir),
      .mtr_nen            (mtr_nen),
      .ccd_en             (ccd_en),
      .busy               (busy),
      .done               (done),
      .fault              (fault),
      .err_code           (err_code),
      .line_count         (line_count)
   );

   always #5 clk_100M = ~clk_100M;

   // Line-done model: level rises 50 cycles after each capture window opens
   bit ld_en = 1'b0;
   always begin
      @(posedge ccd_en);
      if (ld_en) begin
         repeat (50) @(negedge clk_100M);
         ccd_line_done = 1'b1;
         repeat (4) @(negedge clk_100M);
         ccd_line_done = 1'b0;
      end
   end

   int   home_rise = 0, scan_rise = 0, ccd_rise = 0, done_cnt = 0, fault_cnt = 0;
   int   bad_done = 0, bad_w = 0, overlap = 0, hi_w = 0, ccd_w = 0, last_ccd_w = 0;
   int   exp_hw = 5;
   logic p_step = 1'b0, p_ccd = 1'b0, p_done = 1'b0, p_fault = 1'b0;

   always @(negedge clk_100M) begin
      if (mtr_step && !p_step) begin
         if (mtr_dir) scan_rise++;
         else         home_rise++;
      end
      if (mtr_step) hi_w++;
      else begin
         if (p_step && hi_w != exp_hw) bad_w++;
         hi_w = 0;
      end
      if (ccd_en && !p_ccd) ccd_rise++;
      if (ccd_en) ccd_w++;
      else begin
         if (p_ccd) last_ccd_w = ccd_w;
         ccd_w = 0;
      end
      if (done && !p_done) done_cnt++;
      if (done && p_done) bad_done++;
      if (fault && !p_fault) fault_cnt++;
      if (mtr_step && ccd_en) overlap++;
      p_step  = mtr_step;
      p_ccd   = ccd_en;
      p_done  = done;
      p_fault = fault;
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk_100M);
      #1;
   endtask

   task automatic pulse_start();
      cmd_start = 1'b1;
      tick();
      cmd_start = 1'b0;
   endtask

   task automatic set_cfg(input int lines, input int spl, input int half, input int settle);
      cfg_lines          = 16'(lines);
      cfg_steps_per_line = 8'(spl);
      cfg_step_half      = 16'(half);
      cfg_settle         = 16'(settle);
   endtask

   function automatic int probe(input int sel);
      case (sel)
         0:       return done_cnt;
         1:       return home_rise;
         2:       return scan_rise;
         3:       return ccd_rise;
         default: return fault_cnt;
      endcase
   endfunction

   task automatic wait_for(input string tag, input int sel, input int target, input int bound);
      int i = 0;
      while (probe(sel) < target && i < bound) begin
         tick();
         i++;
      end
      check_val(tag, 32'(probe(sel) >= target), 32'd1);
   endtask

   int b_h, b_s, b_c, b_d, b_w, b_o, b_bd, b_f;

   task automatic snap();
      b_h  = home_rise;
      b_s  = scan_rise;
      b_c  = ccd_rise;
      b_d  = done_cnt;
      b_w  = bad_w;
      b_o  = overlap;
      b_bd = bad_done;
      b_f  = fault_cnt;
   endtask

   initial begin
      nrst      = 1'b0;
      cmd_start = 1'b0;
      cmd_abort = 1'b0;
      mtr_nhome = 1'b1;
      mtr_nflt  = 1'b1;
      set_cfg(0, 0, 1, 0);
      repeat (3) tick();
      check_val("rst_busy",  32'(busy), 32'd0);
      check_val("rst_nen",   32'(mtr_nen), 32'd1);
      check_val("rst_step",  32'(mtr_step), 32'd0);
      check_val("rst_ccd",   32'(ccd_en), 32'd0);
      check_val("rst_fault", 32'(fault), 32'd0);
      check_val("rst_err",   32'(err_code), 32'd0);
      check_val("rst_lc",    32'(line_count), 32'd0);
      nrst = 1'b1;
      tick();

      // Normal scan, with a start pulse during the first capture
      set_cfg(3, 4, 5, 10);
      ld_en = 1'b1;
      exp_hw = 5;
      snap();
      pulse_start();
      check_val("t1_busy", 32'(busy), 32'd1);
      check_val("t1_nen",  32'(mtr_nen), 32'd0);
      wait_for("t1_home_wait", 1, b_h + 2, 500);
      mtr_nhome = 1'b0;
      wait_for("t1_cap_wait", 3, b_c + 1, 500);
      pulse_start();
      check_val("t1_start_ignored_ccd", 32'(ccd_en), 32'd1);
      check_val("t1_start_ignored_busy", 32'(busy), 32'd1);
      wait_for("t1_done_wait", 0, b_d + 1, 3000);
      check_val("t1_done_nen", 32'(mtr_nen), 32'd1);
      check_val("t1_lc",       32'(line_count), 32'd3);
      check_val("t1_home_n",   32'(home_rise - b_h), 32'd2);
      check_val("t1_scan_n",   32'(scan_rise - b_s), 32'd12);
      check_val("t1_ccd_n",    32'(ccd_rise - b_c), 32'd3);
      check_val("t1_width",    32'(bad_w - b_w), 32'd0);
      check_val("t1_overlap",  32'(overlap - b_o), 32'd0);
      repeat (3) tick();
      check_val("t1_done_once", 32'(done_cnt - b_d), 32'd1);
      check_val("t1_done_len",  32'(bad_done - b_bd), 32'd0);
      check_val("t1_idle_busy", 32'(busy), 32'd0);

      // Zero lines: home check then done, no capture
      set_cfg(0, 4, 5, 3);
      snap();
      pulse_start();
      check_val("t2_lc_clr", 32'(line_count), 32'd0);
      wait_for("t2_done_wait", 0, b_d + 1, 300);
      check_val("t2_ccd_n",  32'(ccd_rise - b_c), 32'd0);
      check_val("t2_home_n", 32'(home_rise - b_h), 32'd0);
      repeat (2) tick();

      // Home timeout
      set_cfg(3, 4, 5, 4);
      mtr_nhome = 1'b1;
      snap();
      pulse_start();
      wait_for("t3_fault_wait", 4, b_f + 1, 1000);
      check_val("t3_home_n", 32'(home_rise - b_h), 32'd8);
      check_val("t3_fault",  32'(fault), 32'd1);
      check_val("t3_err",    32'(err_code), 32'd2);
      check_val("t3_nen",    32'(mtr_nen), 32'd1);
      check_val("t3_step",   32'(mtr_step), 32'd0);

      // Capture timeout
      ld_en = 1'b0;
      mtr_nhome = 1'b0;
      set_cfg(2, 1, 2, 4);
      snap();
      pulse_start();
      check_val("t4_fault_clr", 32'(fault), 32'd0);
      check_val("t4_err_clr",   32'(err_code), 32'd0);
      wait_for("t4_fault_wait", 4, b_f + 1, 500);
      check_val("t4_ccd_width", 32'(last_ccd_w), 32'd100);
      check_val("t4_err",       32'(err_code), 32'd3);
      check_val("t4_ccd",       32'(ccd_en), 32'd0);
      check_val("t4_ccd_n",     32'(ccd_rise - b_c), 32'd1);

      // Driver fault during a scan step, then restart and rehome
      ld_en = 1'b1;
      set_cfg(2, 4, 5, 2);
      snap();
      pulse_start();
      wait_for("t5_step_wait", 2, b_s + 1, 500);
      mtr_nflt = 1'b0;
      wait_for("t5_fault_lat", 4, b_f + 1, 3);
      check_val("t5_step", 32'(mtr_step), 32'd0);
      check_val("t5_err",  32'(err_code), 32'd1);
      check_val("t5_nen",  32'(mtr_nen), 32'd1);
      mtr_nflt  = 1'b1;
      mtr_nhome = 1'b1;
      repeat (3) tick();
      snap();
      pulse_start();
      check_val("t5_restart_fault", 32'(fault), 32'd0);
      check_val("t5_restart_err",   32'(err_code), 32'd0);
      wait_for("t5_rehome_wait", 1, b_h + 1, 200);
      check_val("t5_rehome_dir", 32'(mtr_dir), 32'd0);
      mtr_nhome = 1'b0;
      wait_for("t5_done_wait", 0, b_d + 1, 2000);
      check_val("t5_lc", 32'(line_count), 32'd2);
      repeat (2) tick();

      // Abort with simultaneous start during the second capture
      set_cfg(3, 2, 3, 2);
      exp_hw = 3;
      snap();
      pulse_start();
      wait_for("t6_cap2_wait", 3, b_c + 2, 1000);
      repeat (5) tick();
      cmd_abort = 1'b1;
      cmd_start = 1'b1;
      tick();
      cmd_abort = 1'b0;
      cmd_start = 1'b0;
      check_val("t6_busy",  32'(busy), 32'd0);
      check_val("t6_ccd",   32'(ccd_en), 32'd0);
      check_val("t6_nen",   32'(mtr_nen), 32'd1);
      check_val("t6_lc",    32'(line_count), 32'd1);
      check_val("t6_fault", 32'(fault), 32'd0);
      repeat (80) tick();
      check_val("t6_lc_hold",  32'(line_count), 32'd1);
      check_val("t6_no_done",  32'(done_cnt - b_d), 32'd0);
      check_val("t6_no_ccd",   32'(ccd_rise - b_c), 32'd2);
      cmd_abort = 1'b1;
      cmd_start = 1'b1;
      tick();
      cmd_abort = 1'b0;
      cmd_start = 1'b0;
      repeat (3) tick();
      check_val("t6_idle_both_busy", 32'(busy), 32'd0);
      check_val("t6_idle_both_nen",  32'(mtr_nen), 32'd1);

      // Asynchronous reset in the middle of a scan step pulse
      set_cfg(1, 4, 20, 2);
      exp_hw = 20;
      snap();
      pulse_start();
      wait_for("t7_step_wait", 2, b_s + 1, 500);
      repeat (3) tick();
      check_val("t7_step_pre", 32'(mtr_step), 32'd1);
      #2;
      nrst = 1'b0;
      #1;
      check_val("t7_step_async", 32'(mtr_step), 32'd0);
      check_val("t7_busy_async", 32'(busy), 32'd0);
      check_val("t7_nen_async",  32'(mtr_nen), 32'd1);
      check_val("t7_lc_async",   32'(line_count), 32'd0);
      tick();
      nrst = 1'b1;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
